// File: rtl/y86_inst_encoder.sv
// Y86-64 instruction encoder: accepts decoded fields and streams the
// encoded bytes, one per cycle, into instruction memory at a write pointer.
module y86_inst_encoder #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_ifun,
    input  logic [3:0]  in_rA,
    input  logic [3:0]  in_rB,
    input  logic [63:0] in_valC,
    input  logic        base_load,
    input  logic [9:0]  base_addr,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        done,
    output logic [63:0] valP,
    output logic        err_invalid,
    output logic        err_mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] ptr_q, ptr_d;
    logic [10:0] start_q, start_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        err_invalid_q, err_invalid_d;
    logic        err_mem_q, err_mem_d;

    logic [3:0]  cnt_in;
    logic [10:0] ptr_eff;
    logic [11:0] end_eff;
    logic        ovf;

    // Encoded length in bytes; zero marks an icode the encoder rejects.
    function automatic logic [3:0] count_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       count_of = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: count_of = 4'd2;
            4'h7, 4'h8:             count_of = 4'd9;
            4'h3, 4'h4, 4'h5:       count_of = 4'd10;
            default:                count_of = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(
        input logic [3:0]  ic,
        input logic [3:0]  fn,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] vc,
        input logic [3:0]  k
    );
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] j;
        logic [5:0] sh;
        a  = (ic == 4'h3) ? 4'hF : ra;
        b  = (ic == 4'hA || ic == 4'hB) ? 4'hF : rb;
        // valC goes out big-endian; jXX/call have no register byte
        j  = (count_of(ic) == 4'd9) ? 3'(4'd8 - k) : 3'(4'd9 - k);
        sh = {j, 3'b000};
        if (k == 4'd0) begin
            byte_of = {ic, fn};
        end else if (k == 4'd1 && count_of(ic) != 4'd9) begin
            byte_of = {a, b};
        end else begin
            byte_of = vc[sh +: 8];
        end
    endfunction

    assign cnt_in  = count_of(in_icode);
    assign ptr_eff = base_load ? {1'b0, base_addr} : ptr_q;
    assign end_eff = {1'b0, ptr_eff} + {8'd0, cnt_in};
    assign ovf     = end_eff > 12'(MEM_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid && cnt_in != 4'd0) begin
                    state_d = ovf ? ERR : EMIT;
                end
            end
            EMIT: begin
                if (idx_q == cnt_q) begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d         = ptr_q;
        start_d       = start_q;
        icode_d       = icode_q;
        ifun_d        = ifun_q;
        ra_d          = ra_q;
        rb_d          = rb_q;
        valc_d        = valc_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = 10'd0;
        wr_data_d     = 8'd0;
        done_d        = 1'b0;
        err_invalid_d = 1'b0;
        err_mem_d     = err_mem_q;
        case (state_q)
            IDLE: begin
                ptr_d = ptr_eff;
                if (in_valid) begin
                    if (cnt_in == 4'd0) begin
                        err_invalid_d = 1'b1;
                    end else if (ovf) begin
                        err_mem_d = 1'b1;
                    end else begin
                        icode_d   = in_icode;
                        ifun_d    = in_ifun;
                        ra_d      = in_rA;
                        rb_d      = in_rB;
                        valc_d    = in_valC;
                        cnt_d     = cnt_in;
                        start_d   = ptr_eff;
                        idx_d     = 4'd1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_eff[9:0];
                        wr_data_d = {in_icode, in_ifun};
                        if (cnt_in == 4'd1) begin
                            done_d = 1'b1;
                            ptr_d  = ptr_eff + 11'd1;
                        end
                    end
                end
            end
            EMIT: begin
                if (idx_q != cnt_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = start_q[9:0] + {6'd0, idx_q};
                    wr_data_d = byte_of(icode_q, ifun_q, ra_q, rb_q,
                                        valc_q, idx_q);
                    idx_d     = idx_q + 4'd1;
                    if (idx_q == cnt_q - 4'd1) begin
                        done_d = 1'b1;
                        ptr_d  = start_q + {7'd0, cnt_q};
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= 11'd0;
            start_q       <= 11'd0;
            icode_q       <= 4'd0;
            ifun_q        <= 4'd0;
            ra_q          <= 4'd0;
            rb_q          <= 4'd0;
            valc_q        <= 64'd0;
            cnt_q         <= 4'd0;
            idx_q         <= 4'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 10'd0;
            wr_data_q     <= 8'd0;
            done_q        <= 1'b0;
            err_invalid_q <= 1'b0;
            err_mem_q     <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            start_q       <= start_d;
            icode_q       <= icode_d;
            ifun_q        <= ifun_d;
            ra_q          <= ra_d;
            rb_q          <= rb_d;
            valc_q        <= valc_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
            err_invalid_q <= err_invalid_d;
            err_mem_q     <= err_mem_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign done        = done_q;
    assign valP        = {53'd0, ptr_q};
    assign err_invalid = err_invalid_q;
    assign err_mem     = err_mem_q;

endmodule

// File: tb/tb_y86_inst_encoder.sv
// Directed scoreboard bench for y86_inst_encoder: expected byte writes are
// queued when an instruction is sent and popped as the encoder emits them.
module tb_y86_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [3:0]  in_rA;
    logic [3:0]  in_rB;
    logic [63:0] in_valC;
    logic        base_load;
    logic [9:0]  base_addr;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        done;
    logic [63:0] valP;
    logic        err_invalid;
    logic        err_mem;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        logic       last;
    } wr_t;

    wr_t         sb[$];
    logic [10:0] exp_ptr;
    int          vectors = 0;
    int          miscompares = 0;

    y86_inst_encoder #(.MEM_BYTES(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_icode    (in_icode),
        .in_ifun     (in_ifun),
        .in_rA       (in_rA),
        .in_rB       (in_rB),
        .in_valC     (in_valC),
        .base_load   (base_load),
        .base_addr   (base_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .valP        (valP),
        .err_invalid (err_invalid),
        .err_mem     (err_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    task automatic expect_instr(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc,
                                input logic [10:0] start);
        logic [7:0] b[10];
        int         n;
        n = len_of(ic);
        for (int i = 0; i < 10; i++) b[i] = 8'h00;
        b[0] = {ic, fn};
        if (n == 2 || n == 10)
            b[1] = {(ic == 4'h3) ? 4'hF : ra,
                    (ic == 4'hA || ic == 4'hB) ? 4'hF : rb};
        if (n == 9)
            for (int i = 0; i < 8; i++) b[1 + i] = vc[63 - 8 * i -: 8];
        if (n == 10)
            for (int i = 0; i < 8; i++) b[2 + i] = vc[63 - 8 * i -: 8];
        for (int k = 0; k < n; k++)
            sb.push_back('{10'(start + 11'(k)), b[k], k == n - 1});
        exp_ptr = start + 11'(n);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic bl,
                        input logic [9:0] ba);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_icode  = ic;
        in_ifun   = fn;
        in_rA     = ra;
        in_rB     = rb;
        in_valC   = vc;
        base_load = bl;
        base_addr = ba;
        @(negedge clk);
        in_valid  = 1'b0;
        base_load = 1'b0;
    endtask

    task automatic drain();
        int  budget;
        wr_t e;
        budget = 30;
        while (sb.size() != 0 && budget > 0) begin
            check("wr_en_burst", 64'(wr_en), 64'd1);
            if (wr_en) begin
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("done", 64'(done), 64'(e.last));
                if (e.last) check("valP_done", valP, 64'(exp_ptr));
            end
            @(negedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        check("idle_wr_en", 64'(wr_en), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 11'd0;
    endtask

    initial begin
        wr_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_icode  = 4'd0;
        in_ifun   = 4'd0;
        in_rA     = 4'd0;
        in_rB     = 4'd0;
        in_valC   = 64'd0;
        base_load = 1'b0;
        base_addr = 10'd0;
        exp_ptr   = 11'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_invalid", 64'(err_invalid), 64'd0);
        check("rst_err_mem", 64'(err_mem), 64'd0);
        check("rst_valP", valP, 64'd0);
        rst = 1'b0;

        // irmovq: 30 F2 00 00 00 00 00 00 01 02
        expect_instr(4'h3, 4'h0, 4'h5, 4'h2, 64'h0102, exp_ptr);
        send(4'h3, 4'h0, 4'h5, 4'h2, 64'h0102, 1'b0, 10'd0);
        drain();
        check("valP_irmovq", valP, 64'd10);

        expect_instr(4'h6, 4'h1, 4'h1, 4'h2, 64'd0, exp_ptr);
        send(4'h6, 4'h1, 4'h1, 4'h2, 64'd0, 1'b0, 10'd0);
        drain();
        check("valP_addq", valP, 64'd12);

        expect_instr(4'hA, 4'h0, 4'h3, 4'h0, 64'd0, exp_ptr);
        send(4'hA, 4'h0, 4'h3, 4'h0, 64'd0, 1'b0, 10'd0);
        drain();
        check("valP_pushq", valP, 64'd14);

        send(4'hC, 4'h0, 4'h1, 4'h2, 64'd0, 1'b0, 10'd0);
        check("inv_err_invalid", 64'(err_invalid), 64'd1);
        check("inv_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        check("inv_pulse_end", 64'(err_invalid), 64'd0);
        check("inv_wr_en2", 64'(wr_en), 64'd0);
        check("inv_valP", valP, 64'd14);
        check("inv_in_ready", 64'(in_ready), 64'd1);

        expect_instr(4'hB, 4'h0, 4'h5, 4'h7, 64'd0, exp_ptr);
        send(4'hB, 4'h0, 4'h5, 4'h7, 64'd0, 1'b0, 10'd0);
        drain();

        expect_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, exp_ptr);
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 1'b0, 10'd0);
        drain();

        expect_instr(4'h7, 4'h3, 4'h0, 4'h0, 64'h0A0B0C0D0E0F1011, exp_ptr);
        send(4'h7, 4'h3, 4'h0, 4'h0, 64'h0A0B0C0D0E0F1011, 1'b0, 10'd0);
        drain();
        check("valP_jxx", valP, 64'd35);

        // base_load together with acceptance relocates this instruction
        expect_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 11'd100);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b1, 10'd100);
        drain();
        check("valP_bl_accept", valP, 64'd101);

        base_load = 1'b1;
        base_addr = 10'd1023;
        @(negedge clk);
        base_load = 1'b0;
        check("valP_bl_1023", valP, 64'd1023);
        exp_ptr = 11'd1023;
        expect_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, exp_ptr);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 10'd0);
        drain();
        check("valP_full", valP, 64'd1024);

        send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 10'd0);
        check("ovf_err_mem", 64'(err_mem), 64'd1);
        check("ovf_wr_en", 64'(wr_en), 64'd0);
        check("ovf_in_ready", 64'(in_ready), 64'd0);
        base_load = 1'b1;
        base_addr = 10'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            base_load = 1'b0;
            check("err_hold_ready", 64'(in_ready), 64'd0);
            check("err_hold_mem", 64'(err_mem), 64'd1);
            check("err_hold_wr_en", 64'(wr_en), 64'd0);
            check("err_hold_valP", valP, 64'd1024);
        end
        pulse_reset();
        check("clr_err_mem", 64'(err_mem), 64'd0);
        check("clr_valP", valP, 64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);

        base_load = 1'b1;
        base_addr = 10'd1020;
        @(negedge clk);
        base_load = 1'b0;
        send(4'h3, 4'h0, 4'h0, 4'h1, 64'h55, 1'b0, 10'd0);
        check("ovf10_err_mem", 64'(err_mem), 64'd1);
        check("ovf10_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        check("ovf10_wr_en2", 64'(wr_en), 64'd0);
        check("ovf10_in_ready", 64'(in_ready), 64'd0);
        pulse_reset();

        // call aborted by reset while byte 4 is on the bus
        expect_instr(4'h8, 4'h0, 4'h0, 4'h0, 64'h40, exp_ptr);
        send(4'h8, 4'h0, 4'h0, 4'h0, 64'h40, 1'b0, 10'd0);
        for (int k = 0; k < 5; k++) begin
            check("call_wr_en", 64'(wr_en), 64'd1);
            e = sb.pop_front();
            check("call_wr_addr", 64'(wr_addr), 64'(e.addr));
            check("call_wr_data", 64'(wr_data), 64'(e.data));
            if (k < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_ptr = 11'd0;
        check("abort_wr_en", 64'(wr_en), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_valP", valP, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("abort_quiet", 64'(wr_en), 64'd0);

        expect_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, exp_ptr);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 10'd0);
        drain();
        check("valP_after_abort", valP, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/y86_inst_encoder.md
Y86_INST_ENCODER -- requirements
Module: y86_inst_encoder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, the instruction-memory size in bytes.
REQ-002 SHALL have clk  in  1  rising-edge clock.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have in_valid  in  1  instruction fields present.
REQ-005 SHALL have in_ready  out  1  encoder can accept fields.
REQ-006 SHALL have in_icode, in_ifun, in_rA, in_rB  in  4 each  instruction fields.
REQ-007 SHALL have in_valC  in  64  constant or destination.
REQ-008 SHALL have base_load  in  1  load the write pointer.
REQ-009 SHALL have base_addr  in  10  new write pointer.
REQ-010 SHALL have wr_en  out  1  byte write strobe to instruction memory.
REQ-011 SHALL have wr_addr  out  10  byte address.
REQ-012 SHALL have wr_data  out  8  byte value.
REQ-013 SHALL have done  out  1  one-cycle pulse on the last byte of an instruction.
REQ-014 SHALL have valP  out  64  zero-extended write pointer, i.e. the address of the next instruction.
REQ-015 SHALL have err_invalid  out  1  one-cycle pulse when an icode is rejected.
REQ-016 SHALL have err_mem  out  1  sticky flag for memory overflow.

Function
REQ-017 SHALL implement states IDLE, EMIT and ERR; in_ready = 1 only in IDLE.
REQ-018 SHALL treat in_valid && in_ready on a rising edge as acceptance: latch all fields and a byte count.
REQ-019 SHALL use these byte counts:
- halt 0, nop 1, ret 9: 1 byte
- cmovXX 2, OPq 6, pushq A, popq B: 2 bytes
- jXX 7, call 8: 9 bytes
- irmovq 3, rmmovq 4, mrmovq 5: 10 bytes
REQ-020 SHALL write byte 0 as {icode, ifun}.
REQ-021 SHALL write byte 1, for 2-byte and 10-byte forms, as {rA, rB}, with rA forced to 4'hF for irmovq and rB forced to 4'hF for pushq/popq.
REQ-022 SHALL write valC most-significant byte first: bytes 2..9 for 10-byte forms, bytes 1..8 for jXX/call.
REQ-023 SHALL, on an accepted icode C..F, pulse err_invalid for one cycle, write nothing, leave the pointer unchanged and remain in IDLE.
REQ-024 SHALL, on an accepted instruction with pointer + count > MEM_BYTES, set err_mem, write nothing and enter ERR.
REQ-025 SHALL hold ERR, with in_ready = 0 and base_load ignored, until rst.
REQ-026 SHALL otherwise enter EMIT, with acceptance in cycle N:
- byte k (k = 0..count-1) has wr_en = 1, wr_addr = pointer + k, in cycle N+1+k;
- done = 1 in cycle N+count;
- pointer += count at the same edge;
- IDLE, with in_ready = 1, in cycle N+count+1.
REQ-027 SHALL keep the write pointer 11 bits wide, range 0..MEM_BYTES; a pointer equal to MEM_BYTES is legal and rejects any further instruction via REQ-024.
REQ-028 SHALL load the pointer from base_addr when base_load is high in IDLE; base_load is ignored in EMIT.
REQ-029 SHALL, when base_load and acceptance occur in the same cycle, encode the instruction starting at base_addr.
REQ-030 SHALL drive wr_addr and wr_data to 0 whenever wr_en = 0.
REQ-031 SHALL register all outputs except in_ready, which is decoded from state.

Reset
REQ-032 SHALL, while rst is sampled high, set state IDLE, pointer 0, and drive wr_en, done, err_invalid, err_mem, wr_addr, wr_data and valP to 0.
REQ-033 SHALL, on rst during EMIT, abandon the instruction with no further writes from the next cycle; bytes already written are not retracted.
REQ-034 SHALL give rst priority over every other input.

Verification
REQ-035 SHALL cover: reset, then irmovq (3/0, rB=2, valC=0x0102) -> addresses 0..9 receive 30 F2 00 00 00 00 00 00 01 02; done with the 10th byte; valP = 10.
REQ-036 SHALL cover: then addq (6/1, rA=1, rB=2) -> address 10 = 0x61, address 11 = 0x12; valP = 12.
REQ-037 SHALL cover: pushq rA=3, rB=0 at pointer 12 -> bytes 0xA0, 0x3F; then icode 0xC -> err_invalid for 1 cycle, no wr_en, valP stays 14.
REQ-038 SHALL cover: base_load 1023, then halt -> address 1023 = 0x00 and valP = 1024; then nop -> err_mem = 1, no writes, in_ready = 0 until rst.
REQ-039 SHALL cover: base_load 1020, then irmovq -> err_mem = 1 with no writes.
REQ-040 SHALL cover: call (valC = 0x40) with rst asserted during byte 4 -> wr_en = 0 the next cycle; valP = 0; in_ready = 1.
